// File: rtl/seg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_pkg : shared defaults and FSM state encoding for the segment driver
// Rev 1.0
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam int unsigned c_WIDTH_DEF = 64;
  localparam int unsigned c_DIV_DEF   = 2;

  typedef logic [1:0] seg_state_t;

  localparam seg_state_t c_ST_IDLE  = 2'd0;
  localparam seg_state_t c_ST_SHIFT = 2'd1;
  localparam seg_state_t c_ST_LATCH = 2'd2;
  localparam seg_state_t c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seg_clk_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_clk_div : half-period tick generator, restartable by a synchronous clear
// Rev 1.0
// ---------------------------------------------------------------------------
module seg_clk_div
  import seg_pkg::*;
#(
  parameter int unsigned DIV = c_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned         c_CW  = $clog2(DIV + 1);
  localparam logic [c_CW-1:0]     c_TOP = c_CW'(DIV - 1);

  logic [c_CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_shift_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_shift_driver : serialises a segment frame MSB-first to a 595-style chain
// Rev 1.0
// ---------------------------------------------------------------------------
module seg_shift_driver
  import seg_pkg::*;
#(
  parameter int unsigned WIDTH = c_WIDTH_DEF,
  parameter int unsigned DIV   = c_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seg_data,
  input  logic             start,
  input  logic             auto_en,
  output logic             busy,
  output logic             done,
  output logic             seg_clk,
  output logic             seg_dat,
  output logic             seg_latch,
  output logic             seg_clrn
);

  localparam int unsigned     c_BW   = $clog2(WIDTH + 1);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(WIDTH - 1);

  seg_state_t       r_state, w_state_n;
  logic             r_phase, w_phase_n;
  logic [c_BW-1:0]  r_bitcnt, w_bitcnt_n;
  logic [WIDTH-1:0] r_shreg, w_shreg_n;
  logic [WIDTH-1:0] r_snap, w_snap_n;
  logic             w_accept, w_tick, w_div_en;
  logic             w_busy_n, w_done_n, w_clk_n, w_dat_n, w_latch_n;

  assign w_accept = (r_state == c_ST_IDLE) && (start || (auto_en && (seg_data != r_snap)));
  assign w_div_en = (r_state == c_ST_SHIFT) || (r_state == c_ST_LATCH);

  seg_clk_div #(
    .DIV(DIV)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_div_en),
    .o_tick(w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_phase   <= 1'b0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_snap    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_dat   <= 1'b0;
      seg_latch <= 1'b0;
      seg_clrn  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_phase   <= w_phase_n;
      r_bitcnt  <= w_bitcnt_n;
      r_shreg   <= w_shreg_n;
      r_snap    <= w_snap_n;
      busy      <= w_busy_n;
      done      <= w_done_n;
      seg_clk   <= w_clk_n;
      seg_dat   <= w_dat_n;
      seg_latch <= w_latch_n;
      seg_clrn  <= 1'b1;
    end
  end

  // r_phase: 0 = first half (clk low / latch high), 1 = second half
  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_bitcnt_n = r_bitcnt;
    w_shreg_n  = r_shreg;
    w_snap_n   = r_snap;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_n  = c_ST_SHIFT;
          w_phase_n  = 1'b0;
          w_bitcnt_n = '0;
          w_shreg_n  = seg_data;
          w_snap_n   = seg_data;
        end
      end
      c_ST_SHIFT: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_phase_n = 1'b1;
          end else begin
            w_phase_n  = 1'b0;
            w_shreg_n  = r_shreg << 1;
            w_bitcnt_n = r_bitcnt + 1'b1;
            if (r_bitcnt == c_LAST) begin
              w_state_n = c_ST_LATCH;
            end
          end
        end
      end
      c_ST_LATCH: begin
        if (w_tick) begin
          if (!r_phase) begin
            w_phase_n = 1'b1;
          end else begin
            w_phase_n = 1'b0;
            w_state_n = c_ST_DONE;
          end
        end
      end
      c_ST_DONE: w_state_n = c_ST_IDLE;
      default:   w_state_n = c_ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so the pins come straight off flops
  always_comb begin
    w_busy_n  = (w_state_n != c_ST_IDLE);
    w_done_n  = (w_state_n == c_ST_DONE);
    w_clk_n   = (w_state_n == c_ST_SHIFT) && w_phase_n;
    w_dat_n   = (w_state_n == c_ST_SHIFT) && w_shreg_n[WIDTH-1];
    w_latch_n = (w_state_n == c_ST_LATCH) && !w_phase_n;
  end

endmodule
`default_nettype wire

// File: doc/seg_shift_driver.md
SEG_SHIFT_DRIVER -- requirements
Module: seg_shift_driver

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH, 64, number of segment bits shifted per frame.
  DIV, 2, system-clock cycles per half-period of seg_clk; legal range 1 to 255.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk, in, 1, system clock; all state updates on its rising edge.
  rst, in, 1, asynchronous active-high reset.
  seg_data, in, WIDTH, segment pattern from the pixel-map stage; bit WIDTH-1 is shifted first.
  start, in, 1, request one frame transfer.
  auto_en, in, 1, self-start whenever seg_data differs from the last shifted frame.
  busy, out, 1, high while a frame is in progress.
  done, out, 1, one-cycle pulse at frame completion.
  seg_clk, out, 1, serial shift clock to the external shift-register chain.
  seg_dat, out, 1, serial data.
  seg_latch, out, 1, storage-register latch pulse.
  seg_clrn, out, 1, active-low clear to the shift-register chain.
REQ-003 There SHALL be exactly one clock, clk; reset rst SHALL be asynchronous and active-high.

Function
REQ-004 States SHALL be IDLE, SHIFT, LATCH and DONE; the register sampled at frame start is called the snapshot.
REQ-005 In IDLE, start=1 or (auto_en=1 and seg_data != snapshot) SHALL copy seg_data into the snapshot and the shift register, clear the bit counter and the divider, and go to SHIFT.
REQ-006 start SHALL be ignored outside IDLE; there is no request queue.
REQ-007 busy SHALL be 1 in SHIFT, LATCH and DONE, and 0 in IDLE.
REQ-008 In SHIFT, each bit SHALL last 2*DIV cycles: seg_clk low for DIV cycles, then high for DIV cycles.
REQ-009 seg_dat SHALL hold the current MSB of the shift register for the whole bit period, so it changes only while seg_clk is low.
REQ-010 At the end of each bit period the shift register SHALL shift left by one and the bit counter SHALL increment.
REQ-011 After bit WIDTH-1 completes, the FSM SHALL go to LATCH.
REQ-012 LATCH SHALL last 2*DIV cycles: seg_latch high for the first DIV cycles and low for the next DIV cycles; seg_clk SHALL stay low.
REQ-013 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-014 Total latency from the accepting edge to the done cycle SHALL be (2*WIDTH+2)*DIV cycles; with WIDTH=64 and DIV=2 this is 260 cycles.
REQ-015 In IDLE: seg_clk=0, seg_latch=0, seg_dat=0, done=0.
REQ-016 seg_data changes during a frame SHALL NOT affect that frame; auto_en compares against the snapshot only in IDLE.
REQ-017 If start and an auto condition occur together, the FSM SHALL start a single frame.
REQ-018 The divider counter SHALL be ceil(log2(DIV+1)) bits wide and the bit counter ceil(log2(WIDTH+1)) bits wide; neither SHALL wrap mid-frame.
REQ-019 All serial outputs SHALL be driven directly from flip-flops, with no combinational path from inputs.

Reset
REQ-020 While rst=1 the block SHALL be in IDLE with busy=0, done=0, seg_clk=0, seg_dat=0, seg_latch=0, seg_clrn=0, snapshot=0 and counters=0.
REQ-021 seg_clrn SHALL go to 1 on the first clk edge after rst deasserts.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with no done pulse and no latch pulse.

Structure
REQ-023 The state encoding and the default values of WIDTH and DIV SHALL live in a shared package, seg_pkg.
REQ-024 The clock divider SHALL be one sub-module, seg_clk_div, producing a half-period tick and restartable by a synchronous clear.
REQ-025 The shift/FSM datapath SHALL stay in seg_shift_driver.

Verification
REQ-026 Reset then idle: rst pulse, no stimulus -> all outputs at reset values, seg_clrn=1 one edge after release, busy stays 0.
REQ-027 Single frame: DIV=2, seg_data=64'hA5A5_0000_FFFF_1234, start pulse -> 64 rising seg_clk edges; bits sampled on those edges equal the data MSB-first; one seg_latch pulse 2 cycles wide; done exactly 260 cycles after the accept.
REQ-028 Start while busy: extra start pulse at cycle 100 -> ignored; exactly one done pulse.
REQ-029 Auto mode: auto_en=1, seg_data changed from 0 to 64'h1 -> frame starts without start; seg_data held constant afterwards -> no further frame.
REQ-030 Mid-frame data change: seg_data altered at cycle 50 -> shifted bits still match the accepted pattern.
REQ-031 Reset mid-frame: rst at cycle 120 -> outputs at reset values asynchronously, no done; a new start afterwards completes normally.
